// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register, result select, register file with
//               same-cycle write bypass, and a retired-write debug counter.
// Revision    : 1.0
// ============================================================================
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic [ADDR_W-1:0] destAddM,
  input  logic [DATA_W-1:0] MemReadDataM,
  input  logic [DATA_W-1:0] alu_resultM,
  input  logic [ADDR_W-1:0] rs_addrD,
  input  logic [ADDR_W-1:0] rt_addrD,
  output logic [DATA_W-1:0] rs_dataD,
  output logic [DATA_W-1:0] rt_dataD,
  output logic              RegWriteW,
  output logic [ADDR_W-1:0] destAddW,
  output logic [DATA_W-1:0] resultW,
  output logic [15:0]       retired_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [ADDR_W-1:0] dest_q,     dest_d;
  logic [DATA_W-1:0] memdata_q,  memdata_d;
  logic [DATA_W-1:0] alu_q,      alu_d;
  logic [15:0]       cnt_q,      cnt_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              w_wr_en;

  // Flush beats stall; a stall holds every field of the MEM/WB register.
  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    dest_d     = dest_q;
    memdata_d  = memdata_q;
    alu_d      = alu_q;
    if (flushW) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      dest_d     = '0;
      memdata_d  = '0;
      alu_d      = '0;
    end else if (!stallW) begin
      regwrite_d = RegWriteM;
      memtoreg_d = MemToRegM;
      dest_d     = destAddM;
      memdata_d  = MemReadDataM;
      alu_d      = alu_resultM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      dest_q     <= '0;
      memdata_q  <= '0;
      alu_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      dest_q     <= dest_d;
      memdata_q  <= memdata_d;
      alu_q      <= alu_d;
    end
  end

  assign RegWriteW = regwrite_q;
  assign destAddW  = dest_q;
  assign resultW   = memtoreg_q ? memdata_q : alu_q;

  assign w_wr_en = regwrite_q && (dest_q != '0);

  // A stalled write repeats with identical data, so it is counted only when it leaves.
  always_comb begin
    cnt_d = cnt_q;
    if (w_wr_en && !stallW) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (w_wr_en) begin
        regs_q[dest_q] <= resultW;
      end
    end
  end

  assign retired_cnt = cnt_q;

  assign rs_dataD = (rs_addrD == '0) ? '0 :
                    (RegWriteW && (destAddW == rs_addrD)) ? resultW : regs_q[rs_addrD];
  assign rt_dataD = (rt_addrD == '0) ? '0 :
                    (RegWriteW && (destAddW == rt_addrD)) ? resultW : regs_q[rt_addrD];

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Vector table plus directed sequences for writeback_stage.
// Revision    : 1.0
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallW, flushW, RegWriteM, MemToRegM;
  logic [3:0]  destAddM, rs_addrD, rt_addrD, destAddW;
  logic [15:0] MemReadDataM, alu_resultM, rs_dataD, rt_dataD, resultW, retired_cnt;
  logic        RegWriteW;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .stallW(stallW), .flushW(flushW),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .destAddM(destAddM),
    .MemReadDataM(MemReadDataM), .alu_resultM(alu_resultM),
    .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .rs_dataD(rs_dataD), .rt_dataD(rt_dataD),
    .RegWriteW(RegWriteW), .destAddW(destAddW), .resultW(resultW), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        m2r;
    logic [3:0]  dest;
    logic [15:0] mem;
    logic [15:0] alu;
    logic [15:0] exp_res;
    logic [15:0] exp_rs;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [3:0]  dest;
    logic [15:0] res;
    logic [15:0] rs;
  } exp_t;

  vec_t        vecs [7];
  exp_t        sb [$];
  logic [15:0] model_regs [16];
  int          exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic wr, input logic m2r, input logic [3:0] dest,
                         input logic [15:0] mem, input logic [15:0] alu);
    RegWriteM    = wr;
    MemToRegM    = m2r;
    destAddM     = dest;
    MemReadDataM = mem;
    alu_resultM  = alu;
  endtask

  task automatic bubble();
    drive_m(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
  endtask

  task automatic read_all_regs(input string name);
    for (int a = 0; a < 16; a++) begin
      rs_addrD = 4'(a);
      rt_addrD = 4'(15 - a);
      #1;
      chk({name, "_rs"}, rs_dataD, model_regs[a]);
      chk({name, "_rt"}, rt_dataD, model_regs[15 - a]);
    end
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{1'b1, 1'b0, 4'd3,  16'hAAAA, 16'h1234, 16'h1234, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 4'd5,  16'hBEEF, 16'h1111, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 4'd6,  16'h0000, 16'h5555, 16'h5555, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 4'd15, 16'h8001, 16'h0000, 16'h8001, 16'h8001};
    vecs[5] = '{1'b1, 1'b0, 4'd3,  16'h0000, 16'h00FF, 16'h00FF, 16'h00FF};
    vecs[6] = '{1'b1, 1'b1, 4'd10, 16'hFFFF, 16'h007F, 16'hFFFF, 16'hFFFF};

    reset = 1'b0; stallW = 1'b0; flushW = 1'b0;
    rs_addrD = 4'd0; rt_addrD = 4'd0;
    bubble();
    for (int a = 0; a < 16; a++) model_regs[a] = 16'h0;
    exp_cnt = 0;
    #1;
    chk("reset_regwrite", RegWriteW, 1'b0);
    chk("reset_dest", destAddW, 4'd0);
    chk("reset_result", resultW, 16'h0);
    chk("reset_cnt", retired_cnt, 16'h0);
    step();
    reset = 1'b1;
    step();

    // Vector table through the scoreboard; rs port watches the destination for bypass.
    for (int i = 0; i < 7; i++) begin
      drive_m(vecs[i].wr, vecs[i].m2r, vecs[i].dest, vecs[i].mem, vecs[i].alu);
      rs_addrD = vecs[i].dest;
      sb.push_back('{vecs[i].wr, vecs[i].dest, vecs[i].exp_res, vecs[i].exp_rs});
      if (vecs[i].wr && vecs[i].dest != 4'd0) begin
        model_regs[vecs[i].dest] = vecs[i].exp_res;
        exp_cnt++;
      end
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d_regwrite", i), RegWriteW, e.wr);
      chk($sformatf("vec%0d_dest", i), destAddW, e.dest);
      chk($sformatf("vec%0d_result", i), resultW, e.res);
      chk($sformatf("vec%0d_bypass", i), rs_dataD, e.rs);
    end
    bubble();
    step();
    chk("table_cnt", retired_cnt, exp_cnt);
    read_all_regs("table_regs");

    // Bypass must show the new value while the regfile still holds the old one.
    drive_m(1'b1, 1'b1, 4'd5, 16'h1357, 16'h0000);
    step();
    rs_addrD = 4'd5; rt_addrD = 4'd5;
    bubble();
    #1;
    chk("bypass_rs", rs_dataD, 16'h1357);
    chk("bypass_rt", rt_dataD, 16'h1357);
    chk("bypass_old_reg", dut.regs_q[5], 16'hBEEF);
    step();
    model_regs[5] = 16'h1357; exp_cnt++;
    chk("bypass_after_write", rs_dataD, 16'h1357);
    chk("bypass_cnt", retired_cnt, exp_cnt);

    // Stall three cycles holding a write to r7; count only on release.
    drive_m(1'b1, 1'b0, 4'd7, 16'h0000, 16'h0777);
    step();
    stallW = 1'b1;
    bubble();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_dest", k), destAddW, 4'd7);
      chk($sformatf("stall%0d_regwrite", k), RegWriteW, 1'b1);
      chk($sformatf("stall%0d_cnt", k), retired_cnt, exp_cnt);
    end
    stallW = 1'b0;
    step();
    model_regs[7] = 16'h0777; exp_cnt++;
    chk("stall_release_cnt", retired_cnt, exp_cnt);
    chk("stall_release_regwrite", RegWriteW, 1'b0);

    // Flush with stall: bubble loaded, pending write still lands, not counted.
    drive_m(1'b1, 1'b0, 4'd8, 16'h0000, 16'h0888);
    step();
    flushW = 1'b1; stallW = 1'b1;
    step();
    flushW = 1'b0; stallW = 1'b0;
    model_regs[8] = 16'h0888;
    chk("flush_regwrite", RegWriteW, 1'b0);
    chk("flush_dest", destAddW, 4'd0);
    chk("flush_result", resultW, 16'h0);
    chk("flush_cnt", retired_cnt, exp_cnt);
    read_all_regs("post_flush_regs");

    // Mid-run reset discards the pending write to r9.
    drive_m(1'b1, 1'b0, 4'd9, 16'h0000, 16'h0999);
    step();
    bubble();
    rs_addrD = 4'd9; rt_addrD = 4'd3;
    reset = 1'b0;
    #1;
    chk("midreset_regwrite", RegWriteW, 1'b0);
    chk("midreset_dest", destAddW, 4'd0);
    chk("midreset_result", resultW, 16'h0);
    chk("midreset_cnt", retired_cnt, 16'h0);
    chk("midreset_rs", rs_dataD, 16'h0);
    chk("midreset_rt", rt_dataD, 16'h0);
    step();
    reset = 1'b1;
    step();
    for (int a = 0; a < 16; a++) model_regs[a] = 16'h0;
    read_all_regs("after_reset_regs");

    // Continuous writes to r1 until the counter wraps.
    drive_m(1'b1, 1'b0, 4'd1, 16'h0000, 16'h4242);
    step();
    chk("wrap_start_cnt", retired_cnt, 16'h0);
    for (int k = 0; k < 65535; k++) step();
    chk("wrap_max_cnt", retired_cnt, 16'hFFFF);
    step();
    chk("wrap_zero_cnt", retired_cnt, 16'h0000);
    rs_addrD = 4'd1;
    bubble();
    step();
    chk("wrap_reg1", rs_dataD, 16'h4242);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
